muldiv_seq: RTL and testbench

- Multi-cycle sequencer implementing the RV32M multiply/divide instructions by iterating the shared 32-bit ALU. It issues add steps for shift-add multiply and subtract steps for restoring division.
- Sits beside the integer ALU in EX. It owns the ALU operand/opcode lines while busy; the core mux hands the ALU back when busy=0.
- Sign handling and fast paths are local; only the per-bit add/subtract goes through the ALU.

---
 rtl/muldiv_seq_pkg.sv | 39 +++
 rtl/muldiv_signfix.sv | 17 +
 rtl/muldiv_seq.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package muldiv_seq_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // RV32M funct3 codes
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    // Opcodes of the shared integer ALU that the sequencer borrows
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    // rs1 is treated as two's complement for these ops
    function automatic logic rs1_is_signed(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_MULHSU) || (f == MD_DIV) || (f == MD_REM);
    endfunction

    // rs2 is treated as two's complement for these ops
    function automatic logic rs2_is_signed(input logic [2:0] f);
        return (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate (abs on entry, sign restore on exit).
// Latency: purely combinational.
// Backpressure: not applicable.
module muldiv_signfix #(
    parameter int W = 64
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);

    // Negate when requested, otherwise pass through
    always_comb begin
        res_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M mul/div sequencer driving the shared ALU one add/subtract step per cycle.
// Latency: start->valid 35 cycles, 2 cycles for divide-by-zero / signed overflow.
// Backpressure: start is only taken when idle; a start while busy is dropped. Optional kill via MULDIV_KILL_EN.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
`ifdef MULDIV_KILL_EN
    input  logic            kill,
`endif
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            valid,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alufn,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_cf
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    state_e            state_q;
    logic              busy_q, valid_q, neg_q;
    logic [XLEN-1:0]   result_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q;   // a_q becomes the ALU b-operand magnitude after SETUP
    logic [XLEN-1:0]   hi_q, lo_q; // {hi,lo} product, or {rem,quo} for divide

    logic              kill_w;
    logic              is_div, is_rem, sa, sb, div_zero, div_ovf, in_iter, ovf;
    logic [XLEN-1:0]   abs_a, abs_b, rsh, hi_d, lo_d, fast_res, fix_res;
    logic [2*XLEN-1:0] fix_in, fix_out;

`ifdef MULDIV_KILL_EN
    assign kill_w = kill;
`else
    assign kill_w = 1'b0;
`endif

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign result = result_q;

    assign is_div  = op_q[2];
    assign is_rem  = op_q[2] & op_q[1];
    assign in_iter = (state_q == S_ITER);
    assign sa      = rs1_is_signed(op_q) & a_q[XLEN-1];
    assign sb      = rs2_is_signed(op_q) & b_q[XLEN-1];

    // Divide corner cases that bypass the iteration entirely
    assign div_zero = is_div && (b_q == '0);
    assign div_ovf  = is_div && !op_q[0] && (a_q == INT_MIN) && (b_q == '1);
    assign fast_res = div_zero ? (is_rem ? a_q : '1) : (is_rem ? '0 : INT_MIN);

    // Operand magnitudes, consumed in SETUP
    muldiv_signfix #(.W(XLEN)) u_abs_a (.val_i(a_q), .neg_i(sa), .res_o(abs_a));
    muldiv_signfix #(.W(XLEN)) u_abs_b (.val_i(b_q), .neg_i(sb), .res_o(abs_b));

    // Sign restore, consumed in FIXUP: 64-bit for products, low 32 bits for quotient/remainder
    assign fix_in = is_div ? {{XLEN{1'b0}}, (is_rem ? hi_q : lo_q)} : {hi_q, lo_q};
    muldiv_signfix #(.W(2*XLEN)) u_fix (.val_i(fix_in), .neg_i(neg_q), .res_o(fix_out));
    assign fix_res = (is_div || (op_q == MD_MUL)) ? fix_out[XLEN-1:0] : fix_out[2*XLEN-1:XLEN];

    // Remainder shifted left with the next dividend bit; the bit shifted out forces a subtract
    assign rsh = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
    assign ovf = hi_q[XLEN-1];

    // ALU lines are owned only while iterating; idle value is 0/0/ADD
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        alufn = ALU_ADD;
        if (in_iter) begin
            alu_a = is_div ? rsh : hi_q;
            alu_b = a_q;
            alufn = is_div ? ALU_SUB : ALU_ADD;
        end
    end

    // One shift-add or restoring-subtract step from the ALU result
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (is_div) begin
            if (alu_cf || ovf) begin
                hi_d = alu_out;
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = rsh;
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            if (lo_q[0]) begin
                hi_d = {alu_cf, alu_out[XLEN-1:1]};
                lo_d = {alu_out[0], lo_q[XLEN-1:1]};
            end else begin
                hi_d = {1'b0, hi_q[XLEN-1:1]};
                lo_d = {hi_q[0], lo_q[XLEN-1:1]};
            end
        end
    end

    // Sequencer FSM with registered busy/valid/result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
            op_q     <= MD_MUL;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (kill_w && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !kill_w) begin
                            op_q    <= funct3;
                            a_q     <= rs1;
                            b_q     <= rs2;
                            busy_q  <= 1'b1;
                            state_q <= S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        neg_q <= is_rem ? sa : (sa ^ sb);
                        cnt_q <= '0;
                        hi_q  <= '0;
                        lo_q  <= is_div ? abs_a : abs_b;
                        a_q   <= is_div ? abs_b : abs_a;
                        if (div_zero || div_ovf) begin
                            result_q <= fast_res;
                            valid_q  <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= S_DONE;
                        end else begin
                            state_q <= S_ITER;
                        end
                    end
                    S_ITER: begin
                        hi_q  <= hi_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_ITER) begin
                            state_q <= S_FIXUP;
                        end
                    end
                    S_FIXUP: begin
                        result_q <= fix_res;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq with an arithmetic reference model and an ALU model.
// Latency: checks 35-cycle normal and 2-cycle fast-path start-to-valid timing.
// Backpressure: checks that start while busy is ignored (and kill when MULDIV_KILL_EN is defined).
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic        busy, valid;
    logic [31:0] result, alu_a, alu_b, alu_out;
    logic [3:0]  alufn;
    logic        alu_cf;
`ifdef MULDIV_KILL_EN
    logic        kill = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int vcount = 0;

    always #5 clk = ~clk;

    muldiv_seq dut (
        .clk(clk), .rst(rst),
`ifdef MULDIV_KILL_EN
        .kill(kill),
`endif
        .start(start), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .busy(busy), .valid(valid), .result(result),
        .alu_a(alu_a), .alu_b(alu_b), .alufn(alufn),
        .alu_out(alu_out), .alu_cf(alu_cf)
    );

    // Shared ALU model: add gives carry-out, subtract gives 1 when no borrow
    always_comb begin
        if (alufn == ALU_SUB) {alu_cf, alu_out} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        else                  {alu_cf, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
    end

    // Count valid pulses, sampled away from the active edge
    always @(negedge clk) if (valid) vcount++;

    // RV32M reference results from plain arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        case (op)
            MD_MUL:    begin p = {32'd0, a} * {32'd0, b};             r = p[31:0];  end
            MD_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
            MD_MULHSU: begin p = {{32{a[31]}}, a} * {32'd0, b};       r = p[63:32]; end
            MD_MULHU:  begin p = {32'd0, a} * {32'd0, b};             r = p[63:32]; end
            MD_DIV:    if (b == 0) r = '1; else if (a == 32'h8000_0000 && b == '1) r = a;
                       else r = $signed(a) / $signed(b);
            MD_DIVU:   r = (b == 0) ? '1 : a / b;
            MD_REM:    if (b == 0) r = a; else if (a == 32'h8000_0000 && b == '1) r = '0;
                       else r = $signed(a) % $signed(b);
            default:   r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 2;
        if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == '1) return 2;
        return 35;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Issue one request and wait (bounded) for valid; returns result, latency and busy profile
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output bit busy_ok);
        busy_ok = 1'b1;
        start = 1'b1; funct3 = op; rs1 = a; rs2 = b;
        @(negedge clk);
        start = 1'b0; rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
        lat = 1;
        while (!valid && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy) busy_ok = 1'b0;
        res = result;
        @(negedge clk);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t        tbl[10];
    logic [31:0] res, a, b, prev;
    logic [2:0]  op;
    int          lat, v0;
    bit          bok;

    initial begin
        tbl[0] = '{MD_MUL,    32'd7,          32'd6,          32'd42,         35};
        tbl[1] = '{MD_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  35};
        tbl[2] = '{MD_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  35};
        tbl[3] = '{MD_MULHU,  32'hFFFF_FFFF,  32'd2,          32'h0000_0001,  35};
        tbl[4] = '{MD_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  35};
        tbl[5] = '{MD_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  35};
        tbl[6] = '{MD_DIVU,   32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  35};
        tbl[7] = '{MD_DIVU,   32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  2};
        tbl[8] = '{MD_REM,    32'h0000_1234,  32'd0,          32'h0000_1234,  2};
        tbl[9] = '{MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_busy",   32'(busy),   32'd0);
        chk("reset_valid",  32'(valid),  32'd0);
        chk("reset_result", result,      32'd0);
        chk("reset_alu_a",  alu_a,       32'd0);
        chk("reset_alu_b",  alu_b,       32'd0);
        chk("reset_alufn",  32'(alufn),  32'(ALU_ADD));
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 10; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat, bok);
            chk($sformatf("vec%0d_result", i), res, tbl[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("vec%0d_busy", i), 32'(bok), 32'd1);
            chk($sformatf("vec%0d_held", i), result, tbl[i].exp);
        end

        // ALU lines are released outside ITER, driven with SUB while dividing
        start = 1'b1; funct3 = MD_DIVU; rs1 = 32'd100; rs2 = 32'd7;
        @(negedge clk); start = 1'b0;
        chk("setup_alu_a", alu_a, 32'd0);
        chk("setup_alufn", 32'(alufn), 32'(ALU_ADD));
        @(negedge clk);
        chk("iter_alufn", 32'(alufn), 32'(ALU_SUB));
        chk("iter_alu_b", alu_b, 32'd7);
        repeat (40) @(negedge clk);

        // Reset in the middle of the iteration
        v0 = vcount;
        start = 1'b1; funct3 = MD_MUL; rs1 = 32'd9; rs2 = 32'd9;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy",   32'(busy),  32'd0);
        chk("midrst_result", result,     32'd0);
        chk("midrst_alu_a",  alu_a,      32'd0);
        chk("midrst_alu_b",  alu_b,      32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_no_valid", 32'(vcount - v0), 32'd0);
        do_op(MD_MUL, 32'd7, 32'd6, res, lat, bok);
        chk("after_rst_result", res, 32'd42);

        // Start while busy is dropped, not queued
        v0 = vcount;
        start = 1'b1; funct3 = MD_MUL; rs1 = 32'd5; rs2 = 32'd5;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; funct3 = MD_DIVU; rs1 = 32'd100; rs2 = 32'd0;
        @(negedge clk); start = 1'b0;
        lat = 6;
        while (!valid && lat < 100) begin @(negedge clk); lat++; end
        chk("busy_start_latency", 32'(lat), 32'd35);
        chk("busy_start_result", result, 32'd25);
        repeat (10) @(negedge clk);
        chk("busy_start_pulses", 32'(vcount - v0), 32'd1);

`ifdef MULDIV_KILL_EN
        // Kill during ITER: no valid, result retained
        prev = result;
        v0 = vcount;
        start = 1'b1; funct3 = MD_MUL; rs1 = 32'd3; rs2 = 32'd3;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        kill = 1'b1;
        @(negedge clk); kill = 1'b0;
        chk("kill_busy", 32'(busy), 32'd0);
        repeat (40) @(negedge clk);
        chk("kill_no_valid", 32'(vcount - v0), 32'd0);
        chk("kill_result", result, prev);
        // Kill together with start drops the request
        start = 1'b1; kill = 1'b1; funct3 = MD_DIVU; rs1 = 32'd1; rs2 = 32'd0;
        @(negedge clk); start = 1'b0; kill = 1'b0;
        chk("kill_start_busy", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("kill_start_no_valid", 32'(vcount - v0), 32'd0);
`endif

        // Randomized back-to-back traffic against the reference model
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
                3: b = 32'($urandom_range(1, 3)) | (b & 32'h8000_0000);
                default: ;
            endcase
            do_op(op, a, b, res, lat, bok);
            chk($sformatf("rnd%0d_op%0d_result", i, op), res, ref_model(op, a, b));
            chk($sformatf("rnd%0d_op%0d_latency", i, op), 32'(lat), 32'(ref_lat(op, a, b)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
